uop_fetch_multi: RTL and testbench

Parametrised microcode fetch unit that sequences reads from a synchronous uop store and delivers FETCH_WIDTH instruction slots per word, each with its own branch tag and slot-valid bit, through a QUEUE_DEPTH output queue with a valid/ready handshake. It supports a redirecting flush, an end-of-sequence marker that halts fetch, and address wrap-around. It sits between the uop store and decode inside microcode_unit.

---
 rtl/uop_fetch_multi.sv | 140 ++++++++++++++
 tb/tb_uop_fetch_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uop_fetch_multi.sv
// uop_fetch_multi: microcode fetch unit between the uop store and decode.
// Reads one uop word per cycle from a synchronous store (1-cycle latency) and
// delivers FETCH_WIDTH instruction slots per word through a small output queue.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   flush, flush_addr  drop queue and in-flight read, restart fetch at flush_addr
//   uop_rd_en, uop_addr, uop   uop store read port (data valid 1 cycle after strobe)
//   out_valid, out_ready       head-of-queue handshake
//   out_instr, out_tag, out_slot_valid   head entry fields, slot i in lane i
//   stalled, halted, queue_count         status
module uop_fetch_multi #(
    parameter int unsigned UOP_BUF_SIZE      = 128,
    parameter int unsigned FETCH_WIDTH       = 2,
    parameter int unsigned MAX_PREDICT_DEPTH = 3,
    parameter int unsigned TAG_BITS          = $clog2(MAX_PREDICT_DEPTH),
    parameter int unsigned QUEUE_DEPTH       = 4,
    parameter int unsigned RESET_ADDR        = 0,
    parameter int unsigned UOP_BUF_WIDTH     = FETCH_WIDTH*(32+TAG_BITS)+FETCH_WIDTH+1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [$clog2(UOP_BUF_SIZE)-1:0]     flush_addr,
    output logic                                uop_rd_en,
    output logic [$clog2(UOP_BUF_SIZE)-1:0]     uop_addr,
    input  logic [UOP_BUF_WIDTH-1:0]            uop,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [FETCH_WIDTH*32-1:0]           out_instr,
    output logic [FETCH_WIDTH*TAG_BITS-1:0]     out_tag,
    output logic [FETCH_WIDTH-1:0]              out_slot_valid,
    output logic                                stalled,
    output logic                                halted,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]    queue_count
);

    localparam int unsigned AW    = $clog2(UOP_BUF_SIZE);
    localparam int unsigned QCW   = $clog2(QUEUE_DEPTH+1);
    localparam int unsigned PW    = $clog2(QUEUE_DEPTH);
    localparam int unsigned PLW   = UOP_BUF_WIDTH - 1;   // stored payload: word without end bit
    localparam int unsigned INS_W = FETCH_WIDTH*32;
    localparam int unsigned TAG_W = FETCH_WIDTH*TAG_BITS;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    pc_q;
    logic             pending_q;
    logic [QCW-1:0]   count_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PLW-1:0]   mem_q [QUEUE_DEPTH];

    logic             run_c;
    logic             credit_c;
    logic             issue_c;
    logic             enq_c;
    logic             end_c;
    logic             pop_c;
    logic [PLW-1:0]   head_w;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == QUEUE_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Credit counts the in-flight read so a response always finds a free entry.
    assign credit_c = (32'(count_q) + 32'(pending_q)) < QUEUE_DEPTH;
    assign run_c    = (state_q == ST_RUN) && !reset && !flush;
    assign issue_c  = run_c && credit_c;
    assign enq_c    = pending_q && !flush && !reset;
    assign end_c    = enq_c && uop[UOP_BUF_WIDTH-1];

    assign uop_rd_en   = issue_c;
    assign uop_addr    = pc_q;
    assign stalled     = run_c && !credit_c;
    assign halted      = (state_q == ST_HALT);
    assign queue_count = count_q;

    // Head entry; flush and reset hide it for the cycle so no pop can occur.
    assign out_valid = (count_q != '0) && !flush && !reset;
    assign pop_c     = out_valid && out_ready;
    assign head_w    = (count_q != '0) ? mem_q[head_q] : '0;

    assign out_instr      = head_w[INS_W-1:0];
    assign out_tag        = head_w[INS_W +: TAG_W];
    assign out_slot_valid = head_w[INS_W+TAG_W +: FETCH_WIDTH];

    // Control state: run/halt, pc, in-flight read and queue pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= AW'(RESET_ADDR);
            pending_q <= 1'b0;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
        end else if (flush) begin
            state_q   <= ST_RUN;
            pc_q      <= flush_addr;
            pending_q <= 1'b0;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            // A read issued alongside an arriving end word is dropped (never enqueued).
            pending_q <= issue_c && !end_c;
            if (issue_c && !end_c) begin
                pc_q <= pc_q + AW'(1);
            end
            if (end_c) begin
                state_q <= ST_HALT;
            end
            if (enq_c) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (pop_c) begin
                head_q <= ptr_inc(head_q);
            end
            case ({enq_c, pop_c})
                2'b10:   count_q <= count_q + QCW'(1);
                2'b01:   count_q <= count_q - QCW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (enq_c) begin
            mem_q[tail_q] <= uop[PLW-1:0];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(enq_c && !pop_c && (32'(count_q) == QUEUE_DEPTH)));

endmodule

// File: tb/tb_uop_fetch_multi.sv
// Directed bench for uop_fetch_multi (FETCH_WIDTH=4, RESET_ADDR=0x7E, 128-word store).
module tb_uop_fetch_multi;

    localparam int unsigned FW  = 4;
    localparam int unsigned TB  = 2;
    localparam int unsigned UW  = FW*(32+TB)+FW+1;
    localparam int unsigned AW  = 7;
    localparam int unsigned QCW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [AW-1:0]   flush_addr;
    logic            uop_rd_en;
    logic [AW-1:0]   uop_addr;
    logic [UW-1:0]   uop;
    logic            out_valid;
    logic            out_ready;
    logic [FW*32-1:0] out_instr;
    logic [FW*TB-1:0] out_tag;
    logic [FW-1:0]   out_slot_valid;
    logic            stalled;
    logic            halted;
    logic [QCW-1:0]  queue_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [UW-1:0] store [128];
    logic [7:0]    got_addr [$];
    logic [3:0]    got_mask [$];
    logic [6:0]    iss_addr [$];
    logic [7:0]    exp_seq  [8] = '{8'h7E, 8'h7F, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    uop_fetch_multi #(
        .UOP_BUF_SIZE(128), .FETCH_WIDTH(FW), .MAX_PREDICT_DEPTH(3),
        .QUEUE_DEPTH(4), .RESET_ADDR('h7E)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_addr(flush_addr),
        .uop_rd_en(uop_rd_en), .uop_addr(uop_addr), .uop(uop),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_tag(out_tag), .out_slot_valid(out_slot_valid), .stalled(stalled),
        .halted(halted), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    // Synchronous store, data valid one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (uop_rd_en) uop <= store[uop_addr];
    end

    // Record pops and issued reads late in the cycle, after inputs have settled.
    always @(negedge clk) begin
        #3;
        if (out_valid && out_ready) begin
            got_addr.push_back(out_instr[15:8]);
            got_mask.push_back(out_slot_valid);
        end
        if (uop_rd_en) iss_addr.push_back(uop_addr);
    end

    function automatic logic [UW-1:0] mk_word(input int a, input logic [3:0] mask, input logic e);
        logic [UW-1:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            w[32*i +: 32]      = 32'hC000_0000 + 32'(a << 8) + 32'(i);
            w[128 + 2*i +: 2]  = 2'(i % 3);
        end
        w[136 +: 4] = mask;
        w[140]      = e;
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 128; a++) store[a] = mk_word(a, 4'hF, 1'b0);
        store[8'h7E] = mk_word('h7E, 4'b0101, 1'b0);
        store[8'h05] = mk_word('h05, 4'hF, 1'b1);
        store[8'h12] = mk_word('h12, 4'h0, 1'b0);

        reset = 1'b1; flush = 1'b0; flush_addr = '0; out_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_rd_en",  128'(uop_rd_en),   128'(0));
        check("rst_valid",  128'(out_valid),   128'(0));
        check("rst_stall",  128'(stalled),     128'(0));
        check("rst_halt",   128'(halted),      128'(0));
        check("rst_count",  128'(queue_count), 128'(0));
        check("rst_instr",  128'(out_instr),   128'(0));

        // Release: addresses 7E,7F,00 with wrap; first delivery two cycles after first read
        reset = 1'b0;
        #1;
        got_addr.delete(); got_mask.delete(); iss_addr.delete();
        check("c0_rd_en", 128'(uop_rd_en), 128'(1));
        check("c0_addr",  128'(uop_addr),  128'(8'h7E));
        tick();
        check("c1_addr",  128'(uop_addr),  128'(8'h7F));
        check("c1_valid", 128'(out_valid), 128'(0));
        tick();
        check("c2_addr",  128'(uop_addr),  128'(8'h00));
        check("c2_valid", 128'(out_valid), 128'(1));
        check("c2_count", 128'(queue_count), 128'(1));
        check("c2_instr", 128'(out_instr), 128'hC0007E03_C0007E02_C0007E01_C0007E00);
        check("c2_tag",   128'(out_tag),   128'(8'h24));
        check("c2_mask",  128'(out_slot_valid), 128'(4'b0101));
        tick();
        check("c3_addr",  128'(uop_addr),  128'(8'h01));
        check("c3_head",  128'(out_instr[31:0]), 128'(32'hC0007F00));

        // Backpressure: queue fills to 4 and reads stop
        out_ready = 1'b0;
        repeat (8) tick();
        check("bp_count", 128'(queue_count), 128'(4));
        check("bp_stall", 128'(stalled),     128'(1));
        check("bp_rd_en", 128'(uop_rd_en),   128'(0));
        check("bp_valid", 128'(out_valid),   128'(1));
        check("bp_head",  128'(out_instr[31:0]), 128'(32'hC0007F00));
        repeat (3) tick();
        check("bp_count2", 128'(queue_count), 128'(4));
        check("bp_issues", 128'(iss_addr.size()), 128'(5));

        // Drain and run into the end word at 0x05
        out_ready = 1'b1;
        for (int i = 0; i < 40 && !halted; i++) tick();
        check("end_halted", 128'(halted), 128'(1));
        repeat (4) tick();
        check("halt_rd_en",  128'(uop_rd_en),   128'(0));
        check("halt_halted", 128'(halted),      128'(1));
        check("halt_valid",  128'(out_valid),   128'(0));
        check("halt_count",  128'(queue_count), 128'(0));
        check("halt_ndeliv", 128'(got_addr.size()), 128'(8));
        for (int i = 0; i < 8; i++) check($sformatf("deliv_%0d", i), 128'(got_addr[i]), 128'(exp_seq[i]));
        check("deliv_mask0", 128'(got_mask[0]), 128'(4'b0101));
        check("deliv_mask7", 128'(got_mask[7]), 128'(4'hF));
        check("iss_n",    128'(iss_addr.size()), 128'(9));
        check("iss_last", 128'(iss_addr[iss_addr.size()-1]), 128'(7'h06));

        // Flush out of HALT to 0x40
        flush = 1'b1; flush_addr = 7'h40;
        #1;
        check("fl1_rd_en", 128'(uop_rd_en), 128'(0));
        check("fl1_halt",  128'(halted),    128'(1));
        check("fl1_stall", 128'(stalled),   128'(0));
        tick();
        flush = 1'b0; out_ready = 1'b0;
        #1;
        check("fl1_run",   128'(halted),    128'(0));
        check("fl1_rd2",   128'(uop_rd_en), 128'(1));
        check("fl1_addr",  128'(uop_addr),  128'(8'h40));
        repeat (4) tick();
        check("pre_fl2_count", 128'(queue_count), 128'(3));
        check("pre_fl2_stall", 128'(stalled),     128'(1));
        check("pre_fl2_head",  128'(out_instr[31:0]), 128'(32'hC0004000));

        // Flush with 3 queued and one read in flight
        out_ready = 1'b1; flush = 1'b1; flush_addr = 7'h10;
        #1;
        check("fl2_valid", 128'(out_valid), 128'(0));
        check("fl2_rd_en", 128'(uop_rd_en), 128'(0));
        tick();
        flush = 1'b0;
        #1;
        got_addr.delete(); got_mask.delete();
        check("fl2_count", 128'(queue_count), 128'(0));
        check("fl2_valid2", 128'(out_valid), 128'(0));
        check("fl2_addr",  128'(uop_addr),  128'(8'h10));
        tick();
        check("fl2_valid3", 128'(out_valid), 128'(0));
        tick();
        check("fl2_valid4", 128'(out_valid), 128'(1));
        check("fl2_head",   128'(out_instr[31:0]), 128'(32'hC0001000));
        repeat (4) tick();
        check("fl2_n",     128'(got_addr.size() >= 3), 128'(1));
        check("fl2_first", 128'(got_addr[0]), 128'(8'h10));
        check("fl2_second",128'(got_addr[1]), 128'(8'h11));
        check("mask0_addr",128'(got_addr[2]), 128'(8'h12));
        check("mask0_val", 128'(got_mask[2]), 128'(4'h0));

        // Reset in the middle of operation
        out_ready = 1'b0;
        repeat (3) tick();
        check("mr_busy",  128'(queue_count != 0), 128'(1));
        reset = 1'b1;
        #1;
        check("mr_rd_en", 128'(uop_rd_en), 128'(0));
        check("mr_valid", 128'(out_valid), 128'(0));
        tick();
        reset = 1'b0;
        #1;
        got_addr.delete(); got_mask.delete();
        check("mr_count", 128'(queue_count), 128'(0));
        check("mr_addr",  128'(uop_addr),    128'(8'h7E));
        check("mr_rd2",   128'(uop_rd_en),   128'(1));
        check("mr_instr", 128'(out_instr),   128'(0));
        out_ready = 1'b1;
        repeat (4) tick();
        check("mr_first",  128'(got_addr[0]), 128'(8'h7E));
        check("mr_second", 128'(got_addr[1]), 128'(8'h7F));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
